// File: rtl/i2s_audio_pkg.sv
// ---------------------------------------------------------------------------
// i2s_audio_pkg : shared types and helpers for the I2S audio receiver. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package i2s_audio_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    SHIFT = 2'd2,
    PAD   = 2'd3
  } state_t;

  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

  function automatic int w_cnt(input int slot_max);
    return (slot_max > 1) ? $clog2(slot_max) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/i2s_sync_edge.sv
// ---------------------------------------------------------------------------
// i2s_sync_edge : w_sync-deep synchroniser with level, rise and change outputs. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module i2s_sync_edge #(
  parameter int w_sync = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic change_o
);

  logic [w_sync-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < w_sync; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[w_sync-1];
    end
  end

  assign level_o  = sync_q[w_sync-1];
  assign rise_o   = sync_q[w_sync-1] & ~prev_q;
  assign change_o = sync_q[w_sync-1] ^ prev_q;

endmodule

`default_nettype wire

// File: rtl/i2s_audio_in.sv
// ---------------------------------------------------------------------------
// i2s_audio_in : I2S slave receiver; stereo when I2S_AUDIO_IN_STEREO_EN is
// defined, otherwise mono (left captured, mirrored on right). Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module i2s_audio_in
  import i2s_audio_pkg::*;
#(
  parameter int w_sample   = 16,
  parameter int w_slot_max = 32,
  parameter int w_sync     = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                bclk,
  input  logic                lrclk,
  input  logic                sdata,
  output logic [w_sample-1:0] left,
  output logic [w_sample-1:0] right,
  output logic                valid,
  output logic                frame_err
);

`ifdef I2S_AUDIO_IN_STEREO_EN
  localparam bit C_STEREO = 1'b1;
`else
  localparam bit C_STEREO = 1'b0;
`endif
  localparam int                 C_CNT_W    = w_cnt(w_slot_max);
  localparam logic [C_CNT_W-1:0] C_CNT_MAX  = C_CNT_W'(w_slot_max - 1);
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(w_sample - 1);

  logic bclk_rise, lr_lvl, lr_edge, sd_lvl;
  logic unused_bclk_lvl, unused_bclk_chg, unused_lr_rise, unused_sd_rise, unused_sd_chg;

  i2s_sync_edge #(.w_sync(w_sync)) u_sync_bclk (
    .clk(clk), .rst(rst), .d_i(bclk),
    .level_o(unused_bclk_lvl), .rise_o(bclk_rise), .change_o(unused_bclk_chg)
  );
  i2s_sync_edge #(.w_sync(w_sync)) u_sync_lrclk (
    .clk(clk), .rst(rst), .d_i(lrclk),
    .level_o(lr_lvl), .rise_o(unused_lr_rise), .change_o(lr_edge)
  );
  i2s_sync_edge #(.w_sync(w_sync)) u_sync_sdata (
    .clk(clk), .rst(rst), .d_i(sdata),
    .level_o(sd_lvl), .rise_o(unused_sd_rise), .change_o(unused_sd_chg)
  );

  state_t              state_q, state_d;
  logic [C_CNT_W-1:0]  cnt_q;
  logic                ch_q;
  logic [w_sample-1:0] shift_q, shift_d, left_hold_q, left_q, right_q;
  logic                valid_q, frame_err_q;
  logic                load, shift_en, word_done, slot_err;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (bclk_rise && lr_edge && (lr_lvl == LEFT)) state_d = DELAY;
      DELAY: if (bclk_rise) begin
               if (lr_edge)                             state_d = DELAY;
               else if (!C_STEREO && (ch_q == RIGHT))   state_d = PAD;
               else                                     state_d = SHIFT;
             end
      SHIFT: if (bclk_rise) begin
               if (lr_edge)                   state_d = DELAY;
               else if (cnt_q == C_CNT_LAST)  state_d = PAD;
             end
      PAD:   if (bclk_rise && lr_edge) state_d = DELAY;
      default: state_d = IDLE;
    endcase
  end

  // Every entry into DELAY is caused by an lr_edge, so load doubles as slot start.
  always_comb begin
    load      = bclk_rise && lr_edge && (state_d == DELAY);
    shift_en  = bclk_rise && !lr_edge && (state_q == SHIFT);
    word_done = shift_en && (cnt_q == C_CNT_LAST);
    slot_err  = bclk_rise && lr_edge &&
                ((state_q == SHIFT) ||
                 ((state_q == DELAY) && (C_STEREO || (ch_q == LEFT))));
  end

  assign shift_d = {shift_q[w_sample-2:0], sd_lvl};

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      ch_q        <= LEFT;
      shift_q     <= '0;
      left_hold_q <= '0;
      left_q      <= '0;
      right_q     <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      valid_q     <= 1'b0;
      frame_err_q <= slot_err;
      if (load) begin
        cnt_q   <= '0;
        ch_q    <= lr_lvl;
        shift_q <= '0;
      end else begin
        if (bclk_rise && ((state_q == SHIFT) || (state_q == PAD)) && (cnt_q != C_CNT_MAX))
          cnt_q <= cnt_q + C_CNT_W'(1);
        if (shift_en)
          shift_q <= shift_d;
      end
      if (word_done) begin
        if (C_STEREO && (ch_q == LEFT)) begin
          left_hold_q <= shift_d;
        end else begin
          left_q  <= C_STEREO ? left_hold_q : shift_d;
          right_q <= shift_d;
          valid_q <= 1'b1;
        end
      end
    end
  end

  assign left      = left_q;
  assign right     = right_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_i2s_audio_in.sv
// ---------------------------------------------------------------------------
// tb_i2s_audio_in : directed bench for i2s_audio_in (16-bit and 24-bit instances). Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_i2s_audio_in;
  import i2s_audio_pkg::*;

  localparam int W_SYNC = 2;
`ifdef I2S_AUDIO_IN_STEREO_EN
  localparam bit STEREO = 1'b1;
`else
  localparam bit STEREO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, bclk, lrclk, sdata;
  logic [15:0] left, right;
  logic        valid, frame_err;
  logic [23:0] left24, right24;
  logic        valid24, frame_err24;

  int cmp = 0;
  int bad = 0;
  int cyc = 0;
  int n_valid, n_err, n_valid24, n_err24, v_cyc, e_cyc;
  int both_hi = 0;
  int hold_viol = 0;
  logic [15:0] prev_l, prev_r;

  i2s_audio_in #(.w_sample(16), .w_slot_max(32), .w_sync(W_SYNC)) dut (
    .clk(clk), .rst(rst), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
    .left(left), .right(right), .valid(valid), .frame_err(frame_err)
  );

  i2s_audio_in #(.w_sample(24), .w_slot_max(32), .w_sync(W_SYNC)) dut24 (
    .clk(clk), .rst(rst), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
    .left(left24), .right(right24), .valid(valid24), .frame_err(frame_err24)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (valid)     begin n_valid++; v_cyc = cyc; end
    if (frame_err) begin n_err++;   e_cyc = cyc; end
    if (valid && frame_err) both_hi++;
    if (!rst && !valid && ((left !== prev_l) || (right !== prev_r))) hold_viol++;
    prev_l = left;
    prev_r = right;
    if (valid24)     n_valid24++;
    if (frame_err24) n_err24++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "time limit");
  end

  task automatic clear_counts();
    n_valid = 0; n_err = 0; n_valid24 = 0; n_err24 = 0; v_cyc = -1; e_cyc = -1;
  endtask

  task automatic do_reset();
    bclk = 1'b0; lrclk = 1'b1; sdata = 1'b0; rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    clear_counts();
  endtask

  // One bclk period: data changes on the fall, lrclk changes together with the rise.
  task automatic send_bit(input logic lr, input logic d, output int rc);
    @(negedge clk); bclk = 1'b0; sdata = d;
    repeat (3) @(negedge clk);
    @(negedge clk); bclk = 1'b1; lrclk = lr; rc = cyc;
    repeat (3) @(negedge clk);
  endtask

  // Slot bit 0 carries the lrclk transition, bit 1 is the delay bit, data MSB from bit 2.
  task automatic send_slot(input logic lr, input int nbits, input logic [31:0] word,
                           input int wbits, output int edge_c, output int lsb_c);
    edge_c = -1;
    lsb_c  = -1;
    for (int j = 0; j < nbits; j++) begin
      logic d;
      int   rc;
      d = 1'b1;
      if (j >= 2 && j < wbits + 2) d = word[wbits + 1 - j];
      send_bit(lr, d, rc);
      if (j == 0) edge_c = rc;
      if (j == wbits + 1) lsb_c = rc;
    end
  endtask

  task automatic test_reset();
    do_reset();
    cmp++; if (left !== 16'h0)    begin bad++; $display("FAIL reset_left: got %h want %h", left, 16'h0); end
    cmp++; if (right !== 16'h0)   begin bad++; $display("FAIL reset_right: got %h want %h", right, 16'h0); end
    cmp++; if (valid !== 1'b0)    begin bad++; $display("FAIL reset_valid: got %b want 0", valid); end
    cmp++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    cmp++; if (left24 !== 24'h0)  begin bad++; $display("FAIL reset_left24: got %h want %h", left24, 24'h0); end
  endtask

  task automatic test_first_frame();
    int e0, l_lsb, r_lsb;
    send_slot(LEFT, 32, 32'h1234, 16, e0, l_lsb);
    cmp++; if (n_valid !== (STEREO ? 0 : 1)) begin bad++; $display("FAIL first_after_left_count: got %0d want %0d", n_valid, (STEREO ? 0 : 1)); end
    send_slot(RIGHT, 32, 32'hABCD, 16, e0, r_lsb);
    cmp++; if (n_valid !== 1) begin bad++; $display("FAIL first_valid_count: got %0d want 1", n_valid); end
    cmp++; if (left !== 16'h1234) begin bad++; $display("FAIL first_left: got %h want %h", left, 16'h1234); end
    cmp++; if (right !== (STEREO ? 16'hABCD : 16'h1234)) begin bad++; $display("FAIL first_right: got %h want %h", right, (STEREO ? 16'hABCD : 16'h1234)); end
    cmp++; if (v_cyc !== (STEREO ? r_lsb : l_lsb) + W_SYNC + 1) begin bad++; $display("FAIL first_latency: got cycle %0d want %0d", v_cyc, (STEREO ? r_lsb : l_lsb) + W_SYNC + 1); end
    cmp++; if (n_err !== 0) begin bad++; $display("FAIL first_err_count: got %0d want 0", n_err); end
  endtask

  task automatic test_mid_slot_start();
    int e0, l0;
    do_reset();
    send_slot(RIGHT, 12, 32'h3A5, 10, e0, l0);
    send_slot(LEFT, 32, 32'h2468, 16, e0, l0);
    send_slot(RIGHT, 32, 32'h1357, 16, e0, l0);
    cmp++; if (n_valid !== 1) begin bad++; $display("FAIL midstart_count: got %0d want 1", n_valid); end
    cmp++; if (left !== 16'h2468) begin bad++; $display("FAIL midstart_left: got %h want %h", left, 16'h2468); end
    cmp++; if (right !== (STEREO ? 16'h1357 : 16'h2468)) begin bad++; $display("FAIL midstart_right: got %h want %h", right, (STEREO ? 16'h1357 : 16'h2468)); end
  endtask

  task automatic test_short_slot();
    int e0, l0, e_edge;
    clear_counts();
    send_slot(LEFT, 32, 32'h0F0F, 16, e0, l0);
    send_slot(RIGHT, 10, 32'hF0F0, 16, e0, l0);
    send_slot(LEFT, 32, 32'hCAFE, 16, e_edge, l0);
    cmp++; if (n_err !== (STEREO ? 1 : 0)) begin bad++; $display("FAIL short_err_count: got %0d want %0d", n_err, (STEREO ? 1 : 0)); end
    cmp++; if (e_cyc !== (STEREO ? e_edge + W_SYNC + 1 : -1)) begin bad++; $display("FAIL short_err_latency: got cycle %0d want %0d", e_cyc, (STEREO ? e_edge + W_SYNC + 1 : -1)); end
    cmp++; if (n_valid !== (STEREO ? 0 : 2)) begin bad++; $display("FAIL short_valid_count: got %0d want %0d", n_valid, (STEREO ? 0 : 2)); end
    cmp++; if (left !== (STEREO ? 16'h2468 : 16'hCAFE)) begin bad++; $display("FAIL short_left_held: got %h want %h", left, (STEREO ? 16'h2468 : 16'hCAFE)); end
    cmp++; if (right !== (STEREO ? 16'h1357 : 16'hCAFE)) begin bad++; $display("FAIL short_right_held: got %h want %h", right, (STEREO ? 16'h1357 : 16'hCAFE)); end
    send_slot(RIGHT, 32, 32'hBEEF, 16, e0, l0);
    cmp++; if (n_valid !== (STEREO ? 1 : 2)) begin bad++; $display("FAIL short_recover_count: got %0d want %0d", n_valid, (STEREO ? 1 : 2)); end
    cmp++; if (left !== 16'hCAFE) begin bad++; $display("FAIL short_recover_left: got %h want %h", left, 16'hCAFE); end
    cmp++; if (right !== (STEREO ? 16'hBEEF : 16'hCAFE)) begin bad++; $display("FAIL short_recover_right: got %h want %h", right, (STEREO ? 16'hBEEF : 16'hCAFE)); end
  endtask

  task automatic test_24bit();
    int e0, l0;
    clear_counts();
    send_slot(LEFT, 32, 32'h800001, 24, e0, l0);
    send_slot(RIGHT, 32, 32'h7FFFFF, 24, e0, l0);
    cmp++; if (n_valid24 !== 1) begin bad++; $display("FAIL w24_count: got %0d want 1", n_valid24); end
    cmp++; if (left24 !== 24'h800001) begin bad++; $display("FAIL w24_left: got %h want %h", left24, 24'h800001); end
    cmp++; if (right24 !== (STEREO ? 24'h7FFFFF : 24'h800001)) begin bad++; $display("FAIL w24_right: got %h want %h", right24, (STEREO ? 24'h7FFFFF : 24'h800001)); end
    cmp++; if (left !== 16'h8000) begin bad++; $display("FAIL w24_narrow_left: got %h want %h", left, 16'h8000); end
    cmp++; if (right !== (STEREO ? 16'h7FFF : 16'h8000)) begin bad++; $display("FAIL w24_narrow_right: got %h want %h", right, (STEREO ? 16'h7FFF : 16'h8000)); end
  endtask

  task automatic test_mid_reset();
    int e0, l0, r_lsb, l_lsb;
    clear_counts();
    send_slot(LEFT, 32, 32'h1111, 16, e0, l0);
    send_slot(RIGHT, 32, 32'h2222, 16, e0, l0);
    send_slot(LEFT, 8, 32'h0, 6, e0, l0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cmp++; if (left !== 16'h0)  begin bad++; $display("FAIL midrst_left: got %h want %h", left, 16'h0); end
    cmp++; if (right !== 16'h0) begin bad++; $display("FAIL midrst_right: got %h want %h", right, 16'h0); end
    cmp++; if (valid !== 1'b0)  begin bad++; $display("FAIL midrst_valid: got %b want 0", valid); end
    cmp++; if (right24 !== 24'h0) begin bad++; $display("FAIL midrst_right24: got %h want %h", right24, 24'h0); end
    clear_counts();
    send_slot(LEFT, 24, 32'hFFFF, 16, e0, l0);
    send_slot(RIGHT, 32, 32'h3333, 16, e0, l0);
    cmp++; if (n_valid !== 0) begin bad++; $display("FAIL midrst_no_valid: got %0d want 0", n_valid); end
    send_slot(LEFT, 32, 32'h4321, 16, e0, l_lsb);
    send_slot(RIGHT, 32, 32'h8765, 16, e0, r_lsb);
    cmp++; if (n_valid !== 1) begin bad++; $display("FAIL midrst_recover_count: got %0d want 1", n_valid); end
    cmp++; if (left !== 16'h4321) begin bad++; $display("FAIL midrst_recover_left: got %h want %h", left, 16'h4321); end
    cmp++; if (right !== (STEREO ? 16'h8765 : 16'h4321)) begin bad++; $display("FAIL midrst_recover_right: got %h want %h", right, (STEREO ? 16'h8765 : 16'h4321)); end
    cmp++; if (v_cyc !== (STEREO ? r_lsb : l_lsb) + W_SYNC + 1) begin bad++; $display("FAIL midrst_latency: got cycle %0d want %0d", v_cyc, (STEREO ? r_lsb : l_lsb) + W_SYNC + 1); end
  endtask

  task automatic test_channel_pattern();
    int e0, l0;
    clear_counts();
    send_slot(LEFT, 32, 32'h00FF, 16, e0, l0);
    send_slot(RIGHT, 32, 32'hFF00, 16, e0, l0);
    cmp++; if (n_valid !== 1) begin bad++; $display("FAIL pattern_count: got %0d want 1", n_valid); end
    cmp++; if (left !== 16'h00FF) begin bad++; $display("FAIL pattern_left: got %h want %h", left, 16'h00FF); end
    cmp++; if (right !== (STEREO ? 16'hFF00 : 16'h00FF)) begin bad++; $display("FAIL pattern_right: got %h want %h", right, (STEREO ? 16'hFF00 : 16'h00FF)); end
  endtask

  task automatic test_invariants();
    cmp++; if (both_hi !== 0)   begin bad++; $display("FAIL valid_and_err_overlap: got %0d want 0", both_hi); end
    cmp++; if (hold_viol !== 0) begin bad++; $display("FAIL output_hold: got %0d changes want 0", hold_viol); end
  endtask

  initial begin
    rst = 1'b1; bclk = 1'b0; lrclk = 1'b1; sdata = 1'b0;
    clear_counts();
    test_reset();
    test_first_frame();
    test_mid_slot_start();
    test_short_slot();
    test_24bit();
    test_mid_reset();
    test_channel_pattern();
    test_invariants();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule

`default_nettype wire
